ntt_core_psi_unpacker: RTL and testbench

- Output-side gearbox of the NTT core.
- Takes one full-width butterfly output word per accepted transfer: PSI*R coefficients, OP_W bits each.
- Emits that word as K = PSI*R/OUT_NB narrower chunks toward the post-NTT consumer.
- It is the counterpart of the input packer that assembles PSI-wide words in front of the core.
- Two-entry ping-pong buffer with valid/ready on both sides; block sob/eob framing is preserved.

---
 rtl/ntt_core_psi_unpacker.sv | 183 ++++++++++++++++++
 tb/tb_ntt_core_psi_unpacker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_core_psi_unpacker.sv
// ntt_core_psi_unpacker
// Output-side gearbox of the NTT core. Each accepted core word carries
// PSI*R coefficients of OP_W bits; it is sent downstream as
// K = PSI*R/OUT_NB chunks of OUT_NB coefficients each. The design holds two
// words in a ping-pong buffer so the next word can be written while the
// current one is still being emitted. Block sob/eob framing is carried through.
//
// Build option: define NTT_CORE_PSI_UNPACK_BITREV_EN to emit the chunks of
// each word in bit-reversed chunk-index order. out_sob and out_eob still mark
// output positions 0 and K-1.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. A valid source keeps its payload stable until that edge. Ready may
// be asserted with or without valid. in_rdy comes from a flop, so it has no
// combinational path from out_rdy.

module ntt_core_psi_unpacker #(
    parameter int PSI    = 128,
    parameter int R      = 2,
    parameter int OP_W   = 64,
    parameter int OUT_NB = 32
) (
    input  logic                     clk,
    input  logic                     a_rst_n,
    input  logic [PSI*R*OP_W-1:0]    in_data,
    input  logic                     in_sob,
    input  logic                     in_eob,
    input  logic                     in_vld,
    output logic                     in_rdy,
    output logic [OUT_NB*OP_W-1:0]   out_data,
    output logic                     out_sob,
    output logic                     out_eob,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     err_frame
);

    localparam int N_COEF  = PSI * R;
    localparam int K       = N_COEF / OUT_NB;
    localparam int CW      = (K > 1) ? $clog2(K) : 1;
    localparam int WORD_W  = N_COEF * OP_W;
    localparam int CHUNK_W = OUT_NB * OP_W;

    // The chunk counter wraps naturally only when K is a power of two.
    generate
        if ((N_COEF % OUT_NB) != 0 || K < 2 || (K & (K - 1)) != 0) begin : g_bad_cfg
            $fatal(1, "ntt_core_psi_unpacker: PSI*R/OUT_NB must be a power of 2 and >= 2");
        end
    endgenerate

    // Ping-pong storage. Each entry holds one word and its framing bits.
    logic [WORD_W-1:0]  buf_data [2];
    logic [1:0]         buf_sob;
    logic [1:0]         buf_eob;
    logic [1:0]         full;
    logic [1:0]         full_nxt;

    logic               wr_ptr;
    logic               wr_ptr_nxt;
    logic               rd_ptr;
    logic               rd_ptr_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [CW-1:0]      sel;

    logic               in_blk;
    logic               in_acc;
    logic               out_acc;
    logic               last_chunk;

    logic [CHUNK_W-1:0] chunks [K];

    assign in_acc     = in_vld & in_rdy;
    assign out_acc    = out_vld & out_rdy;
    assign last_chunk = (cnt == CW'(K - 1));

    // Split the entry being read into its K chunks.
    for (genvar j = 0; j < K; j++) begin : g_chunk
        assign chunks[j] = buf_data[rd_ptr][j*CHUNK_W +: CHUNK_W];
    end

`ifdef NTT_CORE_PSI_UNPACK_BITREV_EN
    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int b = 0; b < CW; b++) begin
            r[b] = v[CW-1-b];
        end
        return r;
    endfunction

    // Output position cnt takes word chunk bitrev(cnt).
    assign sel = bitrev(cnt);
`else
    // Output position cnt takes word chunk cnt.
    assign sel = cnt;
`endif

    // Drive the output from the registered entry, so it holds steady under backpressure.
    always_comb begin
        out_vld  = full[rd_ptr];
        out_data = '0;
        out_sob  = 1'b0;
        out_eob  = 1'b0;
        if (full[rd_ptr]) begin
            out_data = chunks[sel];
            out_sob  = buf_sob[rd_ptr] & (cnt == '0);
            out_eob  = buf_eob[rd_ptr] & last_chunk;
        end
    end

    // Compute next occupancy, pointers and chunk counter.
    // A write needs an empty entry and a release needs a full one, so when both
    // happen in the same cycle they always act on different entries.
    always_comb begin
        full_nxt   = full;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        if (in_acc) begin
            full_nxt[wr_ptr] = 1'b1;
            wr_ptr_nxt       = ~wr_ptr;
        end
        if (out_acc) begin
            if (last_chunk) begin
                cnt_nxt          = '0;
                full_nxt[rd_ptr] = 1'b0;
                rd_ptr_nxt       = ~rd_ptr;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // Register occupancy, pointers and counter. Ready is precomputed from the next state.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            full   <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
            in_rdy <= 1'b1;
        end else begin
            full   <= full_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
            in_rdy <= ~full_nxt[wr_ptr_nxt];
        end
    end

    // Capture an accepted word and its framing into the write entry.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int e = 0; e < 2; e++) begin
                buf_data[e] <= '0;
            end
            buf_sob <= 2'b00;
            buf_eob <= 2'b00;
        end else if (in_acc) begin
            buf_data[wr_ptr] <= in_data;
            buf_sob[wr_ptr]  <= in_sob;
            buf_eob[wr_ptr]  <= in_eob;
        end
    end

    // Track block framing. The error flag is sticky; data keeps flowing after an error.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            in_blk    <= 1'b0;
            err_frame <= 1'b0;
        end else if (in_acc) begin
            if ((in_sob & in_blk & ~in_eob) | (~in_blk & ~in_sob)) begin
                err_frame <= 1'b1;
            end
            if (in_eob) begin
                in_blk <= 1'b0;
            end else if (in_sob) begin
                in_blk <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_core_psi_unpacker.sv
// Bench for ntt_core_psi_unpacker, small config K=4 (PSI=4, R=2, OP_W=8, OUT_NB=2).
// Reference model: each accepted word expands into a queue of expected chunks.
// Buffer occupancy is derived from the queue length. Framing is tracked as block state.

module tb_ntt_core_psi_unpacker;

    localparam int PSI    = 4;
    localparam int R      = 2;
    localparam int OP_W   = 8;
    localparam int OUT_NB = 2;
    localparam int K      = 4;
    localparam int LOG_K  = 2;
    localparam int WW     = PSI * R * OP_W;
    localparam int CWD    = OUT_NB * OP_W;

    logic            clk = 1'b0;
    logic            a_rst_n = 1'b1;
    logic [WW-1:0]   in_data = '0;
    logic            in_sob = 1'b0;
    logic            in_eob = 1'b0;
    logic            in_vld = 1'b0;
    logic            in_rdy;
    logic [CWD-1:0]  out_data;
    logic            out_sob;
    logic            out_eob;
    logic            out_vld;
    logic            out_rdy;
    logic            err_frame;

    // Scoreboard: entries are {sob, eob, data}.
    logic [CWD+1:0]  exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              n_out = 0;
    int              first_out_cyc = -1;
    int              last_out_cyc = -1;
    bit              err_m = 1'b0;
    bit              blk_m = 1'b0;
    int              rdy_mode = 1;

    ntt_core_psi_unpacker #(
        .PSI(PSI), .R(R), .OP_W(OP_W), .OUT_NB(OUT_NB)
    ) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .in_data(in_data), .in_sob(in_sob), .in_eob(in_eob),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_sob(out_sob), .out_eob(out_eob),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .err_frame(err_frame)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Index of the word chunk that appears at output position n.
    function automatic int exp_src(input int n);
`ifdef NTT_CORE_PSI_UNPACK_BITREV_EN
        int r = 0;
        for (int b = 0; b < LOG_K; b++) begin
            r = r * 2 + ((n >> b) & 1);
        end
        return r;
`else
        return n;
`endif
    endfunction

    task automatic push_word(input logic [WW-1:0] w, input bit s, input bit e);
        for (int n = 0; n < K; n++) begin
            logic [WW-1:0] sh;
            sh = w >> (CWD * exp_src(n));
            exp_q.push_back({s && (n == 0), e && (n == K - 1), sh[CWD-1:0]});
        end
    endtask

    // out_rdy source: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_rdy = 1'b0;
                1:       out_rdy = 1'b1;
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare at the falling edge, then apply the transfers of the coming rising edge to the model.
    always @(negedge clk) begin
        cyc++;
        if (!a_rst_n) begin
            check("rst_out_vld", out_vld, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_sob", out_sob, 0);
            check("rst_out_eob", out_eob, 0);
            check("rst_err_frame", err_frame, 0);
            check("rst_in_rdy", in_rdy, 1);
            exp_q.delete();
            err_m = 1'b0;
            blk_m = 1'b0;
        end else begin
            check("out_vld", out_vld, exp_q.size() != 0);
            if (out_vld && exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0][CWD-1:0]);
                check("out_sob", out_sob, exp_q[0][CWD+1]);
                check("out_eob", out_eob, exp_q[0][CWD]);
            end
            check("in_rdy", in_rdy, ((exp_q.size() + K - 1) / K) < 2);
            check("err_frame", err_frame, err_m);
            if (out_vld && out_rdy && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_out++;
                last_out_cyc = cyc;
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
            if (in_vld && in_rdy) begin
                if ((in_sob && blk_m && !in_eob) || (!blk_m && !in_sob)) err_m = 1'b1;
                if (in_eob) blk_m = 1'b0;
                else if (in_sob) blk_m = 1'b1;
                push_word(in_data, in_sob, in_eob);
            end
        end
    end

    // Driver: present one word and hold it until it is accepted.
    task automatic send_word(input logic [WW-1:0] w, input bit s, input bit e);
        bit acc = 1'b0;
        in_data = w;
        in_sob  = s;
        in_eob  = e;
        in_vld  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("send_timeout", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        a_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
    endtask

    function automatic logic [WW-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        int n0;
        bit blk_d;
        bit s;
        bit e;
        #1 a_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_rst_n = 1'b1;

        // Single word, sob and eob set together.
        first_out_cyc = -1;
        send_word(64'h0706050403020100, 1'b1, 1'b1);
        drain("single_drain");
        check("single_span", last_out_cyc - first_out_cyc, K - 1);
        check("single_err", err_frame, 0);

        // Three-word block streamed back to back.
        first_out_cyc = -1;
        n0 = n_out;
        send_word(rand_word(), 1'b1, 1'b0);
        send_word(rand_word(), 1'b0, 1'b0);
        send_word(rand_word(), 1'b0, 1'b1);
        drain("stream_drain");
        check("stream_count", n_out - n0, 3 * K);
        check("stream_span", last_out_cyc - first_out_cyc, 3 * K - 1);

        // Backpressure with both entries full.
        rdy_mode = 0;
        send_word(64'h0706050403020100, 1'b1, 1'b0);
        send_word(rand_word(), 1'b0, 1'b1);
        check("bp_in_rdy", in_rdy, 0);
        check("bp_hold_0", out_data, 16'h0100);
        repeat (10) @(posedge clk);
        #1;
        check("bp_hold_10", out_data, 16'h0100);
        check("bp_in_rdy_10", in_rdy, 0);
        n0 = n_out;
        rdy_mode = 1;
        drain("bp_drain");
        check("bp_count", n_out - n0, 2 * K);

        // First word after reset has no sob.
        do_reset();
        send_word(rand_word(), 1'b0, 1'b1);
        check("frame_err_set", err_frame, 1);
        drain("frame_drain");
        send_word(rand_word(), 1'b1, 1'b1);
        drain("frame_drain2");
        check("frame_err_sticky", err_frame, 1);

        // Reset asserted after two chunks of a word have gone out.
        do_reset();
        send_word(rand_word(), 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        a_rst_n = 1'b0;
        #1;
        check("midrst_vld", out_vld, 0);
        check("midrst_data", out_data, 0);
        check("midrst_in_rdy", in_rdy, 1);
        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        n0 = n_out;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_stale", n_out - n0, 0);
        check("midrst_in_rdy_after", in_rdy, 1);

        // Random traffic with random out_rdy and occasional framing faults.
        do_reset();
        rdy_mode = 2;
        blk_d = 1'b0;
        for (int w = 0; w < 40; w++) begin
            s = !blk_d;
            e = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) s = !s;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_word(rand_word(), s, e);
            if (e) blk_d = 1'b0;
            else if (s) blk_d = 1'b1;
        end
        rdy_mode = 1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
